// File: rtl/sram_bank.sv
// sram_bank: single-port word-addressable SRAM bank with per-lane write mask,
// a pipelined read path of READ_LAT cycles and an automatic zero-fill sweep
// after every reset.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 in every IDLE cycle and 0 during the
// sweep. Reads return exactly one rsp_valid pulse READ_LAT cycles later, in
// order. Writes return nothing.
//
// Optional feature: define SRAM_BANK_PARITY_EN to keep one even-parity bit
// per word and to add the perr_inj / rsp_perr ports.
//
// READ_LAT must be within 1..4.
module sram_bank #(
  parameter int WIDTH    = 73,
  parameter int DEPTH    = 50176,
  parameter int LANE_W   = 8,
  parameter int READ_LAT = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NLANE   = (WIDTH + LANE_W - 1) / LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [NLANE-1:0] req_wmask,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SRAM_BANK_PARITY_EN
  ,
  input  logic             perr_inj,
  output logic             rsp_perr
`endif
);

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             in_range;
  logic             acc;
  logic             rd_acc;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] merged;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] rd_word;

  logic [READ_LAT-1:0] pv_q;
  logic [WIDTH-1:0]    pd_q [READ_LAT];

`ifdef SRAM_BANK_PARITY_EN
  logic                par_q [DEPTH];
  logic                mem_wpar;
  logic                rd_perr;
  logic [READ_LAT-1:0] pp_q;
`endif

  // State register and sweep address; reset always restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next-state logic: sweep one word per cycle, then sit in IDLE accepting.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    req_ready  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_addr_q == LAST_C) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Request decode, lane merge and the single memory write port.
  always_comb begin
    in_range = ({1'b0, req_addr} < DEPTH_C);
    acc      = req_valid && req_ready;
    rd_acc   = acc && !req_we;
    for (int b = 0; b < WIDTH; b++) begin
      bit_mask[b] = req_wmask[b / LANE_W];
    end
    merged    = (mem_q[req_addr] & ~bit_mask) | (req_wdata & bit_mask);
    rd_word   = in_range ? mem_q[req_addr] : '0;
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = '0;
`ifdef SRAM_BANK_PARITY_EN
    mem_wpar  = 1'b0;
    rd_perr   = in_range ? ((^mem_q[req_addr]) ^ par_q[req_addr]) : 1'b0;
`endif
    if (state_q == ST_CLEAR) begin
      mem_we = !rst;
    end else if (acc && req_we && in_range && (|req_wmask)) begin
      mem_we    = !rst;
      mem_waddr = req_addr;
      mem_wdata = merged;
`ifdef SRAM_BANK_PARITY_EN
      mem_wpar  = (^merged) ^ perr_inj;
`endif
    end
  end

  // Storage array; contents are established by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
`ifdef SRAM_BANK_PARITY_EN
      par_q[mem_waddr] <= mem_wpar;
`endif
    end
  end

  // Read pipeline: data only advances alongside a valid, so the last stage
  // holds the previous response while rsp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= '0;
`ifdef SRAM_BANK_PARITY_EN
      pp_q <= '0;
`endif
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) begin
        pd_q[0] <= rd_word;
`ifdef SRAM_BANK_PARITY_EN
        pp_q[0] <= rd_perr;
`endif
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
`ifdef SRAM_BANK_PARITY_EN
          pp_q[i] <= pp_q[i-1];
`endif
        end
      end
    end
  end

  assign rsp_valid = pv_q[READ_LAT-1];
  assign rsp_data  = pd_q[READ_LAT-1];
`ifdef SRAM_BANK_PARITY_EN
  assign rsp_perr  = pp_q[READ_LAT-1];
`endif

endmodule
